// File: rtl/sha256_iter_core.sv
// Iterative SHA-256/SHA-224 compression engine computing RPC rounds per clock.
// Define SHA256_ZEROIZE_EN to add the 'zeroize' port that clears all hash state.
module sha256_iter_core #(
   parameter int RPC         = 1,
   parameter bit SUPPORT_224 = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef SHA256_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [511:0] msg,
   input  logic         msg_first,
   input  logic         mode_224,
   input  logic         load_hash,
   input  logic [255:0] hash_in,
   output logic         hash_valid,
   output logic [255:0] hash_out,
   output logic         busy
);

   generate
      if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
         $error("sha256_iter_core: RPC must be 1, 2, 4 or 8");
      end
   endgenerate

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   state_t      state, state_nxt;
   logic [31:0] h_reg [8];
   logic [31:0] v_reg [8];
   logic [31:0] w_win [16];
   logic [5:0]  cnt;
   logic        mode_q;
   logic        ready_en;
   logic        zero_req;
   logic        accept;
   logic        do_load;
   logic        last_step;
   logic [255:0] iv_sel;

   logic [31:0] ext [16+RPC];
   logic [31:0] rv  [RPC+1][8];
   logic [31:0] t1  [RPC];
   logic [31:0] t2  [RPC];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

`ifdef SHA256_ZEROIZE_EN
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   // A pending load_hash or zeroize steals the IDLE cycle, so the block waits.
   assign msg_ready = ready_en & (state == IDLE) & ~load_hash & ~zero_req;
   assign accept    = msg_valid & msg_ready;
   assign do_load   = load_hash & (state == IDLE) & ~zero_req;
   assign busy      = (state == ROUND) | (state == FINAL);
   assign last_step = ({1'b0, cnt} + 7'(RPC)) == 7'd64;
   assign iv_sel    = (mode_224 & SUPPORT_224) ? IV224 : IV256;
   assign hash_out  = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                       h_reg[4], h_reg[5], h_reg[6], mode_q ? 32'h0 : h_reg[7]};

   // Unrolled round chain: ext[] extends the window by RPC schedule words.
   always_comb begin
      for (int j = 0; j < 16; j++) ext[j] = w_win[j];
      for (int k = 0; k < RPC; k++)
         ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
      for (int j = 0; j < 8; j++) rv[0][j] = v_reg[j];
      for (int i = 0; i < RPC; i++) begin
         t1[i] = rv[i][7] + bsig1(rv[i][4])
               + ((rv[i][4] & rv[i][5]) ^ (~rv[i][4] & rv[i][6]))
               + K[cnt + 6'(i)] + ext[i];
         t2[i] = bsig0(rv[i][0])
               + ((rv[i][0] & rv[i][1]) ^ (rv[i][0] & rv[i][2]) ^ (rv[i][1] & rv[i][2]));
         rv[i+1][0] = t1[i] + t2[i];
         rv[i+1][1] = rv[i][0];
         rv[i+1][2] = rv[i][1];
         rv[i+1][3] = rv[i][2];
         rv[i+1][4] = rv[i][3] + t1[i];
         rv[i+1][5] = rv[i][4];
         rv[i+1][6] = rv[i][5];
         rv[i+1][7] = rv[i][6];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ROUND;
         ROUND:   if (last_step) state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (zero_req) state_nxt = IDLE;
   end

   // Datapath registers; zeroize outranks load, which outranks a new block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            h_reg[i] <= '0;
            v_reg[i] <= '0;
         end
         for (int j = 0; j < 16; j++) w_win[j] <= '0;
         cnt        <= '0;
         mode_q     <= 1'b0;
         ready_en   <= 1'b0;
         hash_valid <= 1'b0;
      end else begin
         ready_en   <= 1'b1;
         hash_valid <= (state == FINAL) & ~zero_req;
         if (zero_req) begin
            for (int i = 0; i < 8; i++) begin
               h_reg[i] <= '0;
               v_reg[i] <= '0;
            end
            for (int j = 0; j < 16; j++) w_win[j] <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
         end else if (do_load) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= hash_in[255-32*i -: 32];
         end else if (accept) begin
            for (int j = 0; j < 16; j++) w_win[j] <= msg[511-32*j -: 32];
            if (msg_first) begin
               for (int i = 0; i < 8; i++) begin
                  h_reg[i] <= iv_sel[255-32*i -: 32];
                  v_reg[i] <= iv_sel[255-32*i -: 32];
               end
               mode_q <= mode_224 & SUPPORT_224;
            end else begin
               for (int i = 0; i < 8; i++) v_reg[i] <= h_reg[i];
            end
            cnt <= '0;
         end else if (state == ROUND) begin
            for (int i = 0; i < 8; i++) v_reg[i] <= rv[RPC][i];
            for (int j = 0; j < 16; j++) w_win[j] <= ext[RPC+j];
            cnt <= cnt + 6'(RPC);
         end else if (state == FINAL) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v_reg[i];
         end
      end
   end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: an RPC=1 and an RPC=8 instance checked against a plain SHA-256 model.
// Also exercises the zeroize port when SHA256_ZEROIZE_EN is defined.
module tb_sha256_iter_core;

   localparam logic [255:0] IV256 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] IV224 =
      256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
   localparam logic [255:0] KAT_ABC256 =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] KAT_ABC224 =
      {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
   localparam logic [255:0] KAT_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] KAT_TWO =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] KTAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   msg_valid, msg_first, mode_224, load_hash;
   logic [511:0] msg [2];
   logic [255:0] hash_in [2];
   logic         msg_ready0, msg_ready1, hash_valid0, hash_valid1, busy0, busy1;
   logic [255:0] hash_out0, hash_out1;
`ifdef SHA256_ZEROIZE_EN
   logic [1:0]   zeroize;
`endif

   int           compares = 0;
   int           mismatches = 0;
   int           pulse0 = 0;
   int           pulse1 = 0;
   logic [255:0] mh [2];
   bit           mm [2];

   always #5 clk = ~clk;

   sha256_iter_core #(.RPC(1), .SUPPORT_224(1'b1)) u_dut_r1 (
      .clk(clk), .rst_n(rst_n),
`ifdef SHA256_ZEROIZE_EN
      .zeroize(zeroize[0]),
`endif
      .msg_valid(msg_valid[0]), .msg_ready(msg_ready0), .msg(msg[0]),
      .msg_first(msg_first[0]), .mode_224(mode_224[0]), .load_hash(load_hash[0]),
      .hash_in(hash_in[0]), .hash_valid(hash_valid0), .hash_out(hash_out0), .busy(busy0)
   );

   sha256_iter_core #(.RPC(8), .SUPPORT_224(1'b1)) u_dut_r8 (
      .clk(clk), .rst_n(rst_n),
`ifdef SHA256_ZEROIZE_EN
      .zeroize(zeroize[1]),
`endif
      .msg_valid(msg_valid[1]), .msg_ready(msg_ready1), .msg(msg[1]),
      .msg_first(msg_first[1]), .mode_224(mode_224[1]), .load_hash(load_hash[1]),
      .hash_in(hash_in[1]), .hash_valid(hash_valid1), .hash_out(hash_out1), .busy(busy1)
   );

   always @(negedge clk) begin
      if (hash_valid0) pulse0++;
      if (hash_valid1) pulse1++;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic getReady(input int d); return d == 0 ? msg_ready0 : msg_ready1; endfunction
   function automatic logic getValid(input int d); return d == 0 ? hash_valid0 : hash_valid1; endfunction
   function automatic logic getBusy(input int d); return d == 0 ? busy0 : busy1; endfunction
   function automatic logic [255:0] getHash(input int d); return d == 0 ? hash_out0 : hash_out1; endfunction
   function automatic int getPulses(input int d); return d == 0 ? pulse0 : pulse1; endfunction
   function automatic int latencyOf(input int d); return d == 0 ? 65 : 9; endfunction

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] dbl;
      dbl = {x, x} >> n;
      return dbl[31:0];
   endfunction

   // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
   function automatic logic [255:0] refCompress(input logic [255:0] hv, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  s0, s1, ch, maj, x1, x2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         s1  = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
         ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
         x1  = v[7] + s1 + ch + KTAB[t] + w[t];
         s0  = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
         maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         x2  = s0 + maj;
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + x1;
         v[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
      return r;
   endfunction

   function automatic logic [255:0] expOut(input int d);
      return mm[d] ? {mh[d][255:32], 32'h0} : mh[d];
   endfunction

   function automatic logic [511:0] randBlock();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [255:0] randHash();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      compares++;
      if (actual !== expected) begin
         mismatches++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Called and returns at a falling edge; hold keeps msg_valid up with the next block queued.
   task automatic applyStimulus(input int d, input logic [511:0] blk, input bit first, input bit m224,
                                input bit hold, input logic [511:0] nblk, input bit nfirst,
                                input bit poke_load, input string tag);
      int n;
      msg[d] = blk; msg_first[d] = first; mode_224[d] = m224; msg_valid[d] = 1'b1;
      #1;
      n = 0;
      while (!getReady(d) && n < 300) begin
         @(negedge clk); #1; n++;
      end
      checkOutput({tag, " ready"}, 256'(getReady(d)), 256'd1);
      @(posedge clk); #1;
      if (first) begin
         mm[d] = m224;
         mh[d] = refCompress(m224 ? IV224 : IV256, blk);
      end else begin
         mh[d] = refCompress(mh[d], blk);
      end
      if (hold) begin
         msg[d] = nblk; msg_first[d] = nfirst;
      end else begin
         msg_valid[d] = 1'b0;
      end
      @(negedge clk);
      checkOutput({tag, " busy/ready"}, 256'({getBusy(d), getReady(d)}), 256'b10);
      n = 0;
      while (!getValid(d) && n < 300) begin
         @(negedge clk); n++;
         if (poke_load && n == 3) begin
            load_hash[d] = 1'b1; hash_in[d] = randHash();
         end
         if (poke_load && n == 4) load_hash[d] = 1'b0;
      end
      checkOutput({tag, " latency"}, 256'(n), 256'(latencyOf(d)));
      checkOutput({tag, " digest"}, getHash(d), expOut(d));
      if (!hold) begin
         @(negedge clk);
         checkOutput({tag, " pulse"}, 256'(getValid(d)), 256'd0);
      end
   endtask

   task automatic loadHash(input int d, input logic [255:0] val, input string tag);
      load_hash[d] = 1'b1; hash_in[d] = val; msg_valid[d] = 1'b1;
      #1;
      checkOutput({tag, " ready_low"}, 256'(getReady(d)), 256'd0);
      @(posedge clk); #1;
      load_hash[d] = 1'b0; msg_valid[d] = 1'b0;
      mh[d] = val;
      @(negedge clk);
      checkOutput({tag, " not_accepted"}, 256'(getBusy(d)), 256'd0);
      checkOutput({tag, " hash"}, getHash(d), expOut(d));
   endtask

   task automatic startBlock(input int d, input logic [511:0] blk);
      int n;
      msg[d] = blk; msg_first[d] = 1'b1; mode_224[d] = 1'b0; msg_valid[d] = 1'b1;
      #1;
      n = 0;
      while (!getReady(d) && n < 300) begin
         @(negedge clk); #1; n++;
      end
      checkOutput("abort ready", 256'(getReady(d)), 256'd1);
      @(posedge clk); #1;
      msg_valid[d] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int p0, p1;
      msg_valid = '0; msg_first = '0; mode_224 = '0; load_hash = '0;
`ifdef SHA256_ZEROIZE_EN
      zeroize = '0;
`endif
      for (int d = 0; d < 2; d++) begin
         msg[d] = '0; hash_in[d] = '0; mh[d] = '0; mm[d] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput("reset ctrl", 256'({getValid(d), getBusy(d), getReady(d)}), 256'b000);
         checkOutput("reset hash", getHash(d), 256'd0);
      end
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) checkOutput("release ready0", 256'(getReady(d)), 256'd0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) checkOutput("release ready1", 256'(getReady(d)), 256'd1);

      applyStimulus(1, randBlock(), 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "chain_from_zero");

      for (int d = 0; d < 2; d++) begin
         $display("[TB] directed tests on instance %0d", d);
         applyStimulus(d, BLK_ABC, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "abc256");
         checkOutput("abc256 kat", getHash(d), KAT_ABC256);
         applyStimulus(d, BLK_ABC, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, "abc224");
         checkOutput("abc224 kat", getHash(d), KAT_ABC224);
         applyStimulus(d, BLK_EMPTY, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "empty");
         checkOutput("empty kat", getHash(d), KAT_EMPTY);
         p0 = getPulses(d);
         applyStimulus(d, BLK_TWO1, 1'b1, 1'b0, 1'b1, BLK_TWO2, 1'b0, 1'b0, "two_blk1");
         applyStimulus(d, BLK_TWO2, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "two_blk2");
         checkOutput("two kat", getHash(d), KAT_TWO);
         checkOutput("two pulses", 256'(getPulses(d) - p0), 256'd2);
         loadHash(d, IV256, "load_iv");
         applyStimulus(d, BLK_ABC, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "abc_after_load");
         checkOutput("abc_after_load kat", getHash(d), KAT_ABC256);
         applyStimulus(d, BLK_ABC, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, "load_while_busy");
         checkOutput("load_while_busy kat", getHash(d), KAT_ABC256);
      end

      for (int d = 0; d < 2; d++) begin
         for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 2) == 0) loadHash(d, randHash(), "rand_load");
            applyStimulus(d, randBlock(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'b0, '0, 1'b0, 1'b0, "rand_blk");
         end
      end

      // Reset in the middle of a block on the RPC=1 instance.
      p1 = pulse0;
      startBlock(0, randBlock());
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         mh[d] = '0; mm[d] = 1'b0;
         checkOutput("midreset hash", getHash(d), 256'd0);
         checkOutput("midreset ctrl", 256'({getValid(d), getBusy(d), getReady(d)}), 256'b000);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset release ready0", 256'(msg_ready0), 256'd0);
      @(negedge clk);
      checkOutput("midreset release ready1", 256'(msg_ready0), 256'd1);
      repeat (80) @(negedge clk);
      checkOutput("midreset no pulse", 256'(pulse0 - p1), 256'd0);
      applyStimulus(0, BLK_ABC, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "abc_after_reset");
      checkOutput("abc_after_reset kat", hash_out0, KAT_ABC256);

`ifdef SHA256_ZEROIZE_EN
      p1 = pulse0;
      startBlock(0, randBlock());
      repeat (29) @(negedge clk);
      zeroize[0] = 1'b1;
      #1;
      checkOutput("zeroize ready", 256'(msg_ready0), 256'd0);
      @(posedge clk); #1;
      zeroize[0] = 1'b0;
      mh[0] = '0; mm[0] = 1'b0;
      @(negedge clk);
      checkOutput("zeroize hash", hash_out0, 256'd0);
      checkOutput("zeroize idle", 256'({busy0, msg_ready0}), 256'b01);
      repeat (80) @(negedge clk);
      checkOutput("zeroize no pulse", 256'(pulse0 - p1), 256'd0);
      applyStimulus(0, BLK_ABC, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "abc_after_zeroize");
      checkOutput("abc_after_zeroize kat", hash_out0, KAT_ABC256);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule

// File: doc/sha256_iter_core.md
Name: sha256_iter_core

Overview:
Parametrised SHA-256/SHA-224 compression engine and the successor to the fixed single-mode sha256 core.
- Accepts one 512-bit padded block per valid/ready handshake.
- Runs 64 rounds at RPC rounds per clock and keeps the chaining value internally for multi-block messages.
- Selects the IV per message (SHA-256 or SHA-224) and supports external chaining-state load.
- Sits behind the PQ accelerator bus wrapper; the wrapper does padding and length appending.

Parameters:
- RPC, 1, rounds computed per clock; legal values 1, 2, 4, 8 (must divide 64); elaboration error otherwise.
- SUPPORT_224, 1, 1 = SHA-224 IV/truncation available; 0 = mode_224 ignored, logic removed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- msg_valid  in  1  block on msg is valid.
- msg_ready  out  1  core can accept a block.
- msg  in  512  padded block, word W0 = msg[511:480], W15 = msg[31:0].
- msg_first  in  1  sampled at accept: 1 = start from IV, 0 = chain from current H.
- mode_224  in  1  sampled at accept when msg_first=1: selects SHA-224 IV and output truncation.
- load_hash  in  1  in IDLE, load H from hash_in.
- hash_in  in  256  external chaining value, H0 = hash_in[255:224].
- hash_valid  out  1  one-cycle pulse: block finished, hash_out updated.
- hash_out  out  256  chaining register H0..H7.
- busy  out  1  high in ROUND/FINAL.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; H, a..h, W window, round counter and stored mode all 0.
  - hash_valid = 0, busy = 0, msg_ready = 0.
  - A ready_en flop sets 1 on the first clk after release; msg_ready = ready_en & IDLE & !load_hash.
- Accept when msg_valid & msg_ready.
  - Latch the 16-word W window.
  - Load a..h from IV (if msg_first; the IV is also written to H) or from H.
  - Go to ROUND with cnt = 0; store mode_224 when msg_first=1.
- ROUND: each cycle applies RPC rounds sequentially in combinational logic.
  - W_t for t ≥ 16 is generated on the fly from the sliding 16-word window (sigma0/sigma1); the window shifts by RPC words.
  - K from a 64-entry constant ROM indexed cnt..cnt+RPC-1.
  - cnt += RPC; when cnt + RPC == 64, go to FINAL.
- FINAL (1 cycle):
  - Hi <= Hi + {a..h}i, mod 2^32 per word.
  - hash_valid = 1 for the following cycle; return to IDLE.
- Latency: accept edge to hash_valid high = 64/RPC + 1 cycles (65 for RPC=1, 9 for RPC=8). Max throughput is one block per 64/RPC + 2 cycles.
- hash_out: driven from H continuously and holds until the next FINAL or load_hash. In SHA-224 mode hash_out[31:0] reads 0 (H7 is still kept internally for chaining).
- load_hash:
  - Effective only in IDLE: H <= hash_in next cycle; msg_ready is low that cycle.
  - load_hash and msg_valid together: load wins and the block is not accepted.
  - Ignored in ROUND/FINAL.
- msg_valid while busy: not accepted. msg and msg_valid must be held stable by the source.
- msg_first=0 with no prior block or load: chains from H = 0 (reset value); this is legal.
- Reset mid-block: all state cleared immediately, no hash_valid, ready returns one cycle after release.

Optional Feature:
- SHA256_ZEROIZE_EN defined:
  - Adds input port zeroize (1 bit).
  - When high on a clock edge: H, a..h, W, cnt and stored mode are cleared to 0 and state = IDLE; any in-flight block is aborted with no hash_valid.
  - Priority over load_hash and accept; msg_ready is low that cycle.
- Not defined: port absent; state cleared only by rst_n.

Test Plan:
- "abc" block (61626380, zeros, last word 00000018), msg_first=1, mode_224=0, RPC=1 -> hash_valid 65 cycles after accept. hash_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Same block with mode_224=1 -> hash_out[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, [31:0] = 0. Repeat with RPC=8 -> same digests, latency 9.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second block msg_first=0), msg_valid held high -> msg_ready low while busy. Final hash_out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; exactly two hash_valid pulses.
- load_hash with hash_in = 6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19, then "abc" with msg_first=0 -> abc digest. load_hash asserted while busy -> no effect.
- Empty message (80000000, zeros) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855. Then rst_n low at round 20 of a new block -> hash_out = 0, no hash_valid, msg_ready 0 during reset and 1 one cycle after release; the next "abc" block is correct.
- SHA256_ZEROIZE_EN: zeroize at round 30 -> no hash_valid, hash_out = 0 next cycle, IDLE; the next "abc" block is correct.
